// File: rtl/data_path_pkg.sv
// Shared constants for the data_path slice: widths, ALU ops, immediate
// formats, write-back selects, jump codes and the immediate extender.
package data_path_pkg;

  localparam int XLEN     = 32;
  localparam int PC_W     = 16;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLTU  = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_TGT = 2'b10;
  localparam logic [1:0] RES_PC4 = 2'b11;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JALR = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_RSVD = 2'b11;  // decoded like JMP_NONE

  // Sign-extend the immediate of the selected format from instr[31].
  function automatic logic [XLEN-1:0] extendImm(input logic [XLEN-1:0] ins,
                                                 input logic [1:0]      fmt);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B: imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J: imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/data_path_if.sv
// Control/data bus between the controller/memory side (master) and the
// data path (slave).
interface data_path_if;
  import data_path_pkg::*;

  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] readData;
  logic            branch;
  logic [1:0]      jump;
  logic [1:0]      resultSrc;
  logic [1:0]      inmSrc;
  logic            regWrite;
  logic            aluSrc;
  logic [2:0]      aluControl;
  logic [XLEN-1:0] aluRes;
  logic            zero;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic            f7;
  logic [XLEN-1:0] writeData;
  logic [PC_W-1:0] pc;

  modport master (
    output instr, readData, branch, jump, resultSrc, inmSrc, regWrite,
           aluSrc, aluControl,
    input  aluRes, zero, op, f3, f7, writeData, pc
  );

  modport slave (
    input  instr, readData, branch, jump, resultSrc, inmSrc, regWrite,
           aluSrc, aluControl,
    output aluRes, zero, op, f3, f7, writeData, pc
  );

endinterface

// File: rtl/rv_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// x0 hard-wired to zero, synchronous clear on rst.
module rv_regfile
  import data_path_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Clear on reset (wins over a write), else write when enabled and rd!=x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/data_path.sv
// Single-cycle RV-style data path: register file, immediate extender, ALU,
// next-pc and write-back muxes, 16-bit pc.
// Optional feature: define DATA_PATH_JALR_EN to let jump=01 take the jalr
// target; otherwise jump=01 falls through to the branch/sequential path.
module data_path
  import data_path_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  data_path_if.slave dp
);

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rs1Data, rs2Data, imm, aluB, aluRes, result;
  logic [PC_W-1:0]   pc, pcPlus4, pcTarget, seqPc, jalrPc, pcNext;
  logic              zero;

  assign rs1 = dp.instr[19:15];
  assign rs2 = dp.instr[24:20];
  assign rd  = dp.instr[11:7];

  rv_regfile uRegfile (
    .clk (clk),
    .rst (rst),
    .we  (dp.regWrite),
    .ra1 (rs1),
    .ra2 (rs2),
    .wa  (rd),
    .wd  (result),
    .rd1 (rs1Data),
    .rd2 (rs2Data)
  );

  assign imm  = extendImm(dp.instr, dp.inmSrc);
  assign aluB = dp.aluSrc ? imm : rs2Data;

  // ALU; all arithmetic wraps modulo 2^32.
  always_comb begin
    aluRes = '0;
    case (dp.aluControl)
      ALU_ADD:   aluRes = rs1Data + aluB;
      ALU_SUB:   aluRes = rs1Data - aluB;
      ALU_AND:   aluRes = rs1Data & aluB;
      ALU_OR:    aluRes = rs1Data | aluB;
      ALU_XOR:   aluRes = rs1Data ^ aluB;
      ALU_SLT:   aluRes = {{(XLEN-1){1'b0}}, $signed(rs1Data) < $signed(aluB)};
      ALU_SLTU:  aluRes = {{(XLEN-1){1'b0}}, rs1Data < aluB};
      ALU_PASSB: aluRes = aluB;
    endcase
  end

  assign zero     = (aluRes == '0);
  assign pcPlus4  = pc + PC_W'(4);
  assign pcTarget = pc + imm[PC_W-1:0];
  assign seqPc    = (dp.branch && zero) ? pcTarget : pcPlus4;

`ifdef DATA_PATH_JALR_EN
  assign jalrPc = {aluRes[PC_W-1:1], 1'b0};
`else
  // jalr disabled: jump=01 is treated exactly like no jump.
  assign jalrPc = seqPc;
`endif

  // Next pc: jal, then jalr, then taken branch, else pc+4.
  always_comb begin
    pcNext = seqPc;
    case (dp.jump)
      JMP_JAL:            pcNext = pcTarget;
      JMP_JALR:           pcNext = jalrPc;
      JMP_NONE, JMP_RSVD: pcNext = seqPc;
    endcase
  end

  // Write-back select; uses the pre-edge pc so jal links old pc+4.
  always_comb begin
    result = aluRes;
    case (dp.resultSrc)
      RES_ALU: result = aluRes;
      RES_MEM: result = dp.readData;
      RES_TGT: result = XLEN'(pcTarget);
      RES_PC4: result = XLEN'(pcPlus4);
    endcase
  end

  // Program counter; reset wins over any update.
  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= pcNext;
  end

  assign dp.aluRes    = aluRes;
  assign dp.zero      = zero;
  assign dp.op        = dp.instr[6:0];
  assign dp.f3        = dp.instr[14:12];
  assign dp.f7        = dp.instr[30];
  assign dp.writeData = rs2Data;
  assign dp.pc        = pc;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus randomized
// cycles compared against an arithmetic reference model.
module tb_data_path;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_path_if bus ();
  data_path dut (.clk(clk), .rst(rst), .dp(bus));

`ifdef DATA_PATH_JALR_EN
  localparam bit JALR = 1'b1;
`else
  localparam bit JALR = 1'b0;
`endif

  int errCnt = 0;
  int chkCnt = 0;
  logic [31:0] mRegs [32];
  logic [15:0] mPc = 16'h0;
  logic [15:0] pcBefore;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Immediate as a signed number: field value minus the weight of the sign bit.
  function automatic logic [31:0] refImm(input logic [31:0] i, input logic [1:0] f);
    int v;
    logic [11:0] f12;
    logic [19:0] f20;
    v = 0;
    case (f)
      2'd0: begin f12 = i[31:20];                          v = int'(f12) - (i[31] ? 4096 : 0); end
      2'd1: begin f12 = {i[31:25], i[11:7]};               v = int'(f12) - (i[31] ? 4096 : 0); end
      2'd2: begin f12 = {i[7], i[30:25], i[11:8], 1'b0};   v = int'(f12) - (i[31] ? 4096 : 0); end
      2'd3: begin f20 = {i[19:12], i[20], i[30:21], 1'b0}; v = int'(f20) - (i[31] ? (1 << 20) : 0); end
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
      default: return b;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins, input logic br, input logic [1:0] jmp,
                       input logic [1:0] rs, input logic [1:0] imS, input logic rw,
                       input logic asrc, input logic [2:0] ctl);
    bus.instr      = ins;
    bus.readData   = $urandom;
    bus.branch     = br;
    bus.jump       = jmp;
    bus.resultSrc  = rs;
    bus.inmSrc     = imS;
    bus.regWrite   = rw;
    bus.aluSrc     = asrc;
    bus.aluControl = ctl;
  endtask

  // Check combinational outputs against the model, clock once, update the model, check pc.
  task automatic doCycle();
    logic [31:0] imm, a, b2, res, wb;
    logic [15:0] tgt, p4, nxt;
    logic [4:0]  rdIdx;
    #1;
    imm = refImm(bus.instr, bus.inmSrc);
    a   = mRegs[bus.instr[19:15]];
    b2  = mRegs[bus.instr[24:20]];
    res = refAlu(a, bus.aluSrc ? imm : b2, bus.aluControl);
    tgt = mPc + imm[15:0];
    p4  = mPc + 16'd4;
    if (!rst) begin
      check("aluRes", bus.aluRes, res);
      check("zero", 32'(bus.zero), (res == 0) ? 32'd1 : 32'd0);
      check("op", 32'(bus.op), 32'(bus.instr[6:0]));
      check("f3", 32'(bus.f3), 32'(bus.instr[14:12]));
      check("f7", 32'(bus.f7), 32'(bus.instr[30]));
      check("writeData", bus.writeData, b2);
    end
    case (bus.resultSrc)
      2'd0: wb = res;
      2'd1: wb = bus.readData;
      2'd2: wb = 32'(tgt);
      default: wb = 32'(p4);
    endcase
    if (bus.jump == 2'b10)                nxt = tgt;
    else if (bus.jump == 2'b01 && JALR)   nxt = {res[15:1], 1'b0};
    else if (bus.branch && res == 32'd0)  nxt = tgt;
    else                                  nxt = p4;
    rdIdx = bus.instr[11:7];
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mPc = 16'h0;
    end else begin
      if (bus.regWrite && rdIdx != 5'd0) mRegs[rdIdx] = wb;
      mPc = nxt;
    end
    check("pc", 32'(bus.pc), 32'(mPc));
  endtask

  task automatic addi(input logic [4:0] rd, input logic [11:0] imm12);
    drive({imm12, 5'd0, 3'd0, rd, 7'h13}, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 3'd0);
    doCycle();
  endtask

  task automatic readReg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    drive({7'h0, idx, 5'd0, 3'd0, 5'd0, 7'h33}, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0);
    #1;
    check(tag, bus.writeData, exp);
    doCycle();
  endtask

  task automatic nop();
    drive(32'h0000_0013, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 3'd0);
    doCycle();
  endtask

  logic [31:0] beq;
  logic [31:0] rins;

  initial begin
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    beq = {1'b1, 6'h3F, 5'd2, 5'd1, 3'd0, 4'hC, 1'b1, 7'h63};  // beq x1,x2,-8

    // Reset with a pending write: registers and pc must end up cleared.
    rst = 1'b1;
    drive($urandom, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 3'd0);
    doCycle();
    doCycle();
    rst = 1'b0;
    check("rstPc", 32'(bus.pc), 32'h0);
    readReg("rstX7", 5'd7, 32'd0);

    // Sequential stepping.
    rst = 1'b1; nop(); rst = 1'b0;
    check("seq0", 32'(bus.pc), 32'h0);
    nop(); check("seq4", 32'(bus.pc), 32'h4);
    nop(); check("seq8", 32'(bus.pc), 32'h8);

    // jal from pc=0 linking pc+4 into x4.
    rst = 1'b1; nop(); rst = 1'b0;
    drive(32'h01A0_0200, 1'b0, 2'b10, 2'b11, 2'b11, 1'b1, 1'b0, 3'd0);
    doCycle();
    readReg("jalLink", 5'd4, 32'd4);

    // add x5,x4,x0 with no write.
    drive(32'h0002_0280, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0);
    #1;
    check("addRes", bus.aluRes, 32'd4);
    check("addZero", 32'(bus.zero), 32'd0);
    check("addOp", 32'(bus.op), 32'h0);
    doCycle();
    readReg("noWrX5", 5'd5, 32'd0);

    // Branch taken / not taken.
    addi(5'd1, 12'd5);
    addi(5'd2, 12'd5);
    pcBefore = mPc;
    drive(beq, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 3'd1);
    doCycle();
    check("beqTaken", 32'(bus.pc), 32'(16'(pcBefore - 16'd8)));
    addi(5'd2, 12'd6);
    pcBefore = mPc;
    drive(beq, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 3'd1);
    doCycle();
    check("beqNotTaken", 32'(bus.pc), 32'(16'(pcBefore + 16'd4)));

    // x0 stays zero; reset beats a simultaneous write.
    addi(5'd0, 12'h07B);
    readReg("x0", 5'd0, 32'd0);
    addi(5'd5, 12'h055);
    rst = 1'b1;
    drive({12'h0AA, 5'd0, 3'd0, 5'd5, 7'h13}, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 3'd0);
    doCycle();
    rst = 1'b0;
    check("rstMidPc", 32'(bus.pc), 32'h0);
    readReg("rstX5", 5'd5, 32'd0);
    readReg("rstX1", 5'd1, 32'd0);

    // pc wrap: jump to 0xFFFC, then pc+4 wraps to 0.
    rst = 1'b1; nop(); rst = 1'b0;
    drive(32'hFFC0_0000, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0);
    doCycle();
    check("pcFFFC", 32'(bus.pc), 32'hFFFC);
    nop();
    check("pcWrap", 32'(bus.pc), 32'h0);

    // jalr x6, 2(x3) with x3=0x101.
    addi(5'd3, 12'h101);
    pcBefore = mPc;
    drive({12'd2, 5'd3, 3'd0, 5'd6, 7'h67}, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1, 1'b1, 3'd0);
    doCycle();
    check("jalrPc", 32'(bus.pc), JALR ? 32'h0102 : 32'(16'(pcBefore + 16'd4)));
    readReg("jalrLink", 5'd6, 32'(16'(pcBefore + 16'd4)));

    // jump=11 behaves as no jump.
    pcBefore = mPc;
    drive(32'h0000_0013, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 3'd0);
    doCycle();
    check("jump11", 32'(bus.pc), 32'(16'(pcBefore + 16'd4)));

    // Randomized cycles.
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      rins = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        rins[24:20] = rins[19:15];
        drive(rins, 1'b1, 2'(($urandom_range(0, 3))), 2'($urandom_range(0, 3)),
              2'b10, 1'($urandom_range(0, 1)), 1'b0, 3'd1);
      end else begin
        drive(rins, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)));
      end
      doCycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
